// File: rtl/gp_core_arbiter.sv
// Two-requester front end for a single grasspopper core: issue register, owner tag FIFO, return.
// Optional build macro GP_ARB_STRICT_PRIO_EN selects fixed priority to requester 0.
module gp_core_arbiter #(
    parameter int unsigned DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   in_valid_i,
    input  logic [127:0] in_data0_i,
    input  logic [127:0] in_data1_i,
    output logic [1:0]   in_ready_o,
    output logic [127:0] core_data_o,
    output logic         core_request_o,
    output logic         core_ack_o,
    input  logic [127:0] core_data_i,
    input  logic         core_valid_i,
    input  logic         core_busy_i,
    output logic [127:0] out_data_o,
    output logic         out_valid_o,
    output logic         out_id_o,
    output logic         err_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

    logic               iss_valid_q, iss_valid_d;
    logic [127:0]       iss_data_q, iss_data_d;
    logic               iss_id_q, iss_id_d;
    logic [DEPTH-1:0]   tag_mem_q, tag_mem_d;
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    tag_count_q, tag_count_d;
    logic               out_valid_q, out_valid_d;
    logic [127:0]       out_data_q, out_data_d;
    logic               out_id_q, out_id_d;
    logic               err_q, err_d;

    logic               accept;
    logic               slot_free;
    logic [CntW-1:0]    inflight;
    logic [1:0]         grant_vec;
    logic               handshake;
    logic               grant_id;
    logic               push;
    logic               pop;
    logic               tag_empty;

`ifndef GP_ARB_STRICT_PRIO_EN
    logic               rr_q, rr_d;
`endif

    assign accept    = iss_valid_q && !core_busy_i;
    assign inflight  = tag_count_q + CntW'(iss_valid_q);
    // Credit uses registered counts only; a pop in this cycle frees a slot next cycle.
    assign slot_free = (!iss_valid_q || accept) && (inflight < DepthC);
    assign tag_empty = (tag_count_q == '0);
    assign push      = accept;
    assign pop       = core_valid_i && !tag_empty;

    always_comb begin
        grant_vec = 2'b00;
        if (slot_free) begin
`ifdef GP_ARB_STRICT_PRIO_EN
            if (in_valid_i[0]) begin
                grant_vec = 2'b01;
            end else if (in_valid_i[1]) begin
                grant_vec = 2'b10;
            end
`else
            unique case (in_valid_i)
                2'b01:   grant_vec = 2'b01;
                2'b10:   grant_vec = 2'b10;
                2'b11:   grant_vec = rr_q ? 2'b10 : 2'b01;
                default: grant_vec = 2'b00;
            endcase
`endif
        end
    end

    // Ready is only raised towards a valid requester, so any ready bit is a handshake.
    assign handshake = |grant_vec;
    assign grant_id  = grant_vec[1];

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_data_d  = iss_data_q;
        iss_id_d    = iss_id_q;
        if (handshake) begin
            iss_valid_d = 1'b1;
            iss_data_d  = grant_id ? in_data1_i : in_data0_i;
            iss_id_d    = grant_id;
        end else if (accept) begin
            iss_valid_d = 1'b0;
        end
    end

`ifndef GP_ARB_STRICT_PRIO_EN
    always_comb begin
        rr_d = rr_q;
        if (handshake) begin
            rr_d = !grant_id;
        end
    end
`endif

    always_comb begin
        tag_mem_d   = tag_mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        tag_count_d = tag_count_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = iss_id_q;
            wr_ptr_d            = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   tag_count_d = tag_count_q + CntW'(1);
            2'b01:   tag_count_d = tag_count_q - CntW'(1);
            default: tag_count_d = tag_count_q;
        endcase
    end

    always_comb begin
        out_valid_d = core_valid_i;
        out_data_d  = core_valid_i ? core_data_i : '0;
        out_id_d    = pop ? tag_mem_q[rd_ptr_q] : 1'b0;
        err_d       = err_q || (core_valid_i && tag_empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_data_q  <= '0;
            iss_id_q    <= 1'b0;
            tag_mem_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_count_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_data_q  <= iss_data_d;
            iss_id_q    <= iss_id_d;
            tag_mem_q   <= tag_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tag_count_q <= tag_count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            err_q       <= err_d;
        end
    end

`ifndef GP_ARB_STRICT_PRIO_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign in_ready_o     = grant_vec;
    assign core_request_o = iss_valid_q;
    assign core_data_o    = iss_data_q;
    assign core_ack_o     = out_valid_q;
    assign out_valid_o    = out_valid_q;
    assign out_data_o     = out_data_q;
    assign out_id_o       = out_id_q;
    assign err_o          = err_q;

endmodule
